// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key schedule, one round key per cycle, indexed read port.
// Define KEYSCHED_ZEROIZE_EN to add a zeroize input that wipes stored round keys and forces IDLE.
module aes_key_sched_ctrl #(
    parameter int NR = 10,
    parameter bit RK_REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] round;
    logic [7:0] rcon;
    logic [127:0] rk [0:NR];
    logic [127:0] prev, rd;
    logic [31:0] t, w0, w1, w2, w3;
    logic accept, last, zap;
`ifdef KEYSCHED_ZEROIZE_EN
    assign zap = zeroize;
`else
    assign zap = 1'b0;
`endif
    always_comb begin
        key_ready = state != EXPAND;
        keys_valid = state == DONE;
        accept = key_valid && key_ready && !zap;
        last = state == EXPAND && round == 4'(NR);
        state_nxt = zap ? IDLE : accept ? EXPAND : last ? DONE : state;
    end
    // RotWord is folded into the S-box byte order: w3 bytes 1,2,3,0
    assign prev = rk[round - 4'd1];
    assign t  = {SBOX[prev[23:16]], SBOX[prev[15:8]], SBOX[prev[7:0]], SBOX[prev[31:24]]} ^ {rcon, 24'h0};
    assign w0 = prev[127:96] ^ t;
    assign w1 = prev[95:64] ^ w0;
    assign w2 = prev[63:32] ^ w1;
    assign w3 = prev[31:0] ^ w2;
    assign rd = rk_idx > 4'(NR) ? '0 : rk[rk_idx];
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            round <= 4'd0;
            rcon <= 8'h01;
        end else if (accept) begin
            round <= 4'd1;
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            round <= round + 4'd1;
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end
    // storage is deliberately untouched by rst
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (zap) for (int i = 0; i <= NR; i++) rk[i] <= '0;
            else if (accept) rk[0] <= key;
            else if (state == EXPAND) rk[round] <= {w0, w1, w2, w3};
        end
    end
    generate
        if (RK_REG_OUT) begin : g_reg
            always_ff @(posedge clk) rk_out <= (rst || zap) ? '0 : rd;
        end else begin : g_comb
            assign rk_out = rd;
        end
    endgenerate
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed FIPS-197 vectors against aes_key_sched_ctrl (registered read port).
// Define KEYSCHED_ZEROIZE_EN to also exercise zeroize.
module tb_aes_key_sched_ctrl;
    localparam logic [127:0] K_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_A1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_A1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_Z_1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K_Z_10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic zeroize = 1'b0;
    logic key_valid = 1'b0;
    logic key_ready;
    logic [127:0] key = '0;
    logic keys_valid;
    logic [3:0] rk_idx = 4'd0;
    logic [127:0] rk_out;
    int checks = 0;
    int errors = 0;
    aes_key_sched_ctrl dut (
        .clk(clk),
        .rst(rst),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key(key),
        .keys_valid(keys_valid),
        .rk_idx(rk_idx),
        .rk_out(rk_out)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic read_rk(input int i, output logic [127:0] v);
        rk_idx = 4'(i);
        tick();
        v = rk_out;
    endtask
    // presents k for one edge, then counts cycles to keys_valid and cycles with key_ready low
    task automatic run_expansion(input logic [127:0] k, input int pulse_at, output int lat, output int busy);
        key = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        lat = -1;
        busy = 0;
        for (int n = 0; n < 30; n++) begin
            if (keys_valid) begin
                lat = n;
                break;
            end
            if (!key_ready) busy++;
            key_valid = (n == pulse_at);
            key = (n == pulse_at) ? '0 : k;
            tick();
        end
        key_valid = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b want 1", key_ready); end
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid got %b want 0", keys_valid); end
        checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out got %h want 0", rk_out); end
        rst = 1'b0;
        tick();
    endtask
    task automatic test_fips(input int pulse_at, input string tag);
        int lat, busy;
        logic [127:0] v;
        run_expansion(K_A1, pulse_at, lat, busy);
        checks++; if (lat !== 10) begin errors++; $display("FAIL %s_latency got %0d want 10", tag, lat); end
        checks++; if (busy !== 10) begin errors++; $display("FAIL %s_busy_cycles got %0d want 10", tag, busy); end
        read_rk(0, v);
        checks++; if (v !== K_A1) begin errors++; $display("FAIL %s_rk0 got %h want %h", tag, v, K_A1); end
        read_rk(1, v);
        checks++; if (v !== K_A1_1) begin errors++; $display("FAIL %s_rk1 got %h want %h", tag, v, K_A1_1); end
        read_rk(10, v);
        checks++; if (v !== K_A1_10) begin errors++; $display("FAIL %s_rk10 got %h want %h", tag, v, K_A1_10); end
    endtask
    task automatic test_read_latency();
        rk_idx = 4'd1;
        tick();
        rk_idx = 4'd10;
        #1;
        checks++; if (rk_out !== K_A1_1) begin errors++; $display("FAIL read_latency_hold got %h want %h", rk_out, K_A1_1); end
        tick();
        checks++; if (rk_out !== K_A1_10) begin errors++; $display("FAIL read_latency_update got %h want %h", rk_out, K_A1_10); end
    endtask
    task automatic test_reload();
        int lat, busy;
        logic [127:0] v;
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL reload_pre_valid got %b want 1", keys_valid); end
        run_expansion(128'h0, -1, lat, busy);
        checks++; if (lat !== 10) begin errors++; $display("FAIL reload_latency got %0d want 10", lat); end
        read_rk(1, v);
        checks++; if (v !== K_Z_1) begin errors++; $display("FAIL reload_rk1 got %h want %h", v, K_Z_1); end
        read_rk(10, v);
        checks++; if (v !== K_Z_10) begin errors++; $display("FAIL reload_rk10 got %h want %h", v, K_Z_10); end
    endtask
    task automatic test_reset_mid();
        logic [127:0] v;
        key = K_A1;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL midrst_key_ready got %b want 1", key_ready); end
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL midrst_keys_valid got %b want 0", keys_valid); end
        test_fips(-1, "midrst_reload");
        for (int i = 11; i < 16; i++) begin
            read_rk(i, v);
            checks++; if (v !== 128'h0) begin errors++; $display("FAIL oob_rk%0d got %h want 0", i, v); end
        end
    endtask
`ifdef KEYSCHED_ZEROIZE_EN
    task automatic test_zeroize();
        logic [127:0] v;
        zeroize = 1'b1;
        key = K_A1;
        key_valid = 1'b1;
        tick();
        zeroize = 1'b0;
        key_valid = 1'b0;
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL zeroize_keys_valid got %b want 0", keys_valid); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL zeroize_key_not_accepted key_ready got %b want 1", key_ready); end
        checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL zeroize_rk_out got %h want 0", rk_out); end
        for (int i = 0; i <= 10; i++) begin
            read_rk(i, v);
            checks++; if (v !== 128'h0) begin errors++; $display("FAIL zeroize_rk%0d got %h want 0", i, v); end
        end
    endtask
`endif
    initial begin
        test_reset();
        test_fips(-1, "fips");
        test_read_latency();
        test_fips(5, "busy_drop");
        test_reload();
        test_reset_mid();
`ifdef KEYSCHED_ZEROIZE_EN
        test_zeroize();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
